// File: rtl/exec_decode_unit_pkg.sv
// rtl/exec_decode_unit_pkg.sv - shared opcode, funct, aluop and aluctl encodings
package exec_decode_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_RSVD   = 2'b11;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_XOR = 4'b1101;

endpackage

// File: rtl/exec_decode_unit_alu_core.sv
// rtl/exec_decode_unit_alu_core.sv - combinational ALU: aluctl, a, b -> result, zero
module exec_alu_core
  import exec_decode_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic slt;

  assign slt = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (aluctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      ALU_NOR: result = ~(a | b);
      ALU_XOR: result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_decode_unit.sv
// rtl/exec_decode_unit.sv - main decode, ALU control, ALU and EX/MEM result register
module exec_decode_unit
  import exec_decode_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b_reg,
  input  logic [WIDTH-1:0] seimm,
  input  logic             hold,
  input  logic             clear,
  output logic             regdst,
  output logic             branch_eq,
  output logic             branch_ne,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrc,
  output logic             jump,
  output logic [1:0]       aluop,
  output logic [3:0]       aluctl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q
);

  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result_d;
  logic             zero_d;

  always_comb begin
    regdst    = 1'b0;
    branch_eq = 1'b0;
    branch_ne = 1'b0;
    memread   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regwrite  = 1'b0;
    alusrc    = 1'b0;
    jump      = 1'b0;
    aluop     = ALUOP_MEM;
    case (opcode)
      OP_RTYPE: begin regdst = 1'b1; regwrite = 1'b1; aluop = ALUOP_FUNCT; end
      OP_LW:    begin memread = 1'b1; memtoreg = 1'b1; alusrc = 1'b1; regwrite = 1'b1; end
      OP_SW:    begin memwrite = 1'b1; alusrc = 1'b1; end
      OP_BEQ:   begin branch_eq = 1'b1; aluop = ALUOP_BRANCH; end
      OP_BNE:   begin branch_ne = 1'b1; aluop = ALUOP_BRANCH; end
      OP_ADDI:  begin alusrc = 1'b1; regwrite = 1'b1; end
      OP_J:     jump = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    aluctl = ALU_ADD;
    case (aluop)
      ALUOP_BRANCH: aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_XOR:  aluctl = ALU_XOR;
          FN_NOR:  aluctl = ALU_NOR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_AND;
        endcase
      end
      default: aluctl = ALU_ADD;
    endcase
  end

  assign operand_b = alusrc ? seimm : b_reg;

  exec_alu_core #(.WIDTH(WIDTH)) u_alu (
    .aluctl (aluctl),
    .a      (a),
    .b      (operand_b),
    .result (result),
    .zero   (zero)
  );

  // Flush wins over stall so a squashed slot never leaks a stale value.
  always_comb begin
    result_d = result;
    zero_d   = zero;
    if (clear) begin
      result_d = '0;
      zero_d   = 1'b0;
    end else if (hold) begin
      result_d = result_q;
      zero_d   = zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule

// File: tb/tb_exec_decode_unit.sv
// tb/tb_exec_decode_unit.sv - table-driven self-checking bench for exec_decode_unit
module tb_exec_decode_unit;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b_reg;
  logic [31:0] seimm;
  logic        hold;
  logic        clear;
  logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] result;
  logic        zero;
  logic [31:0] result_q;
  logic        zero_q;

  int checks;
  int failures;

  typedef struct {
    string       name;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b_reg;
    logic [31:0] seimm;
    logic [8:0]  ctrl;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] result;
    logic        zero;
  } vec_t;

  vec_t vecs[16];

  exec_decode_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .funct     (funct),
    .a         (a),
    .b_reg     (b_reg),
    .seimm     (seimm),
    .hold      (hold),
    .clear     (clear),
    .regdst    (regdst),
    .branch_eq (branch_eq),
    .branch_ne (branch_ne),
    .memread   (memread),
    .memwrite  (memwrite),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrc    (alusrc),
    .jump      (jump),
    .aluop     (aluop),
    .aluctl    (aluctl),
    .result    (result),
    .zero      (zero),
    .result_q  (result_q),
    .zero_q    (zero_q)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] vi);
    opcode = op;
    funct  = fn;
    a      = va;
    b_reg  = vb;
    seimm  = vi;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clk_en   = 1'b0;
    hold     = 1'b0;
    clear    = 1'b0;
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);

    // ctrl = {regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump}
    vecs[0]  = '{"r_add",   6'b000000, 6'b100000, 32'd5,        32'd7,        32'h0,        9'b100000100, 2'b10, 4'b0010, 32'd12,       1'b0};
    vecs[1]  = '{"r_and",   6'b000000, 6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b0000, 32'h00F000F0, 1'b0};
    vecs[2]  = '{"r_or",    6'b000000, 6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b0001, 32'hFFF0FFF0, 1'b0};
    vecs[3]  = '{"r_xor",   6'b000000, 6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b1101, 32'hFF00FF00, 1'b0};
    vecs[4]  = '{"r_nor",   6'b000000, 6'b100111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b1100, 32'h000F000F, 1'b0};
    vecs[5]  = '{"r_sub",   6'b000000, 6'b100010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b0110, 32'hE100E100, 1'b0};
    vecs[6]  = '{"r_slt1",  6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1,        32'h0,        9'b100000100, 2'b10, 4'b0111, 32'd1,        1'b0};
    vecs[7]  = '{"r_slt0",  6'b000000, 6'b101010, 32'd1,        32'hFFFFFFFF, 32'h0,        9'b100000100, 2'b10, 4'b0111, 32'd0,        1'b1};
    vecs[8]  = '{"r_badfn", 6'b000000, 6'b000000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        9'b100000100, 2'b10, 4'b0000, 32'h00F000F0, 1'b0};
    vecs[9]  = '{"beq",     6'b000100, 6'b010101, 32'h1234,     32'h1234,     32'h55,       9'b010000000, 2'b01, 4'b0110, 32'd0,        1'b1};
    vecs[10] = '{"bne",     6'b000101, 6'b000000, 32'd10,       32'd3,        32'h55,       9'b001000000, 2'b01, 4'b0110, 32'd7,        1'b0};
    vecs[11] = '{"lw",      6'b100011, 6'b111100, 32'h100,      32'hDEAD,     32'hFFFFFFFC, 9'b000101110, 2'b00, 4'b0010, 32'h000000FC, 1'b0};
    vecs[12] = '{"sw",      6'b101011, 6'b001000, 32'h200,      32'd99,       32'd8,        9'b000010010, 2'b00, 4'b0010, 32'h208,      1'b0};
    vecs[13] = '{"addi",    6'b001000, 6'b000001, 32'hFFFFFFFF, 32'd77,       32'd1,        9'b000000110, 2'b00, 4'b0010, 32'd0,        1'b1};
    vecs[14] = '{"j",       6'b000010, 6'b100010, 32'd3,        32'd4,        32'd100,      9'b000000001, 2'b00, 4'b0010, 32'd7,        1'b0};
    vecs[15] = '{"illegal", 6'b111111, 6'b100010, 32'd1,        32'd2,        32'd100,      9'b000000000, 2'b00, 4'b0010, 32'd3,        1'b0};

    rst_n = 1'b0;
    #3;
    check("reset_result_q", result_q, 32'd0);
    check("reset_zero_q", {31'd0, zero_q}, 32'd0);
    rst_n = 1'b1;
    #1;
    clk_en = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].opcode, vecs[i].funct, vecs[i].a, vecs[i].b_reg, vecs[i].seimm);
      #1;
      check({vecs[i].name, "_ctrl"},
            {23'd0, regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, alusrc, jump},
            {23'd0, vecs[i].ctrl});
      check({vecs[i].name, "_aluop"}, {30'd0, aluop}, {30'd0, vecs[i].aluop});
      check({vecs[i].name, "_aluctl"}, {28'd0, aluctl}, {28'd0, vecs[i].aluctl});
      check({vecs[i].name, "_result"}, result, vecs[i].result);
      check({vecs[i].name, "_zero"}, {31'd0, zero}, {31'd0, vecs[i].zero});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_result_q"}, result_q, vecs[i].result);
      check({vecs[i].name, "_zero_q"}, {31'd0, zero_q}, {31'd0, vecs[i].zero});
    end

    // hold across an operand change
    @(negedge clk);
    drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
    @(posedge clk);
    #1;
    check("pre_hold_result_q", result_q, 32'd12);
    @(negedge clk);
    hold = 1'b1;
    a = 32'd100;
    #1;
    check("hold_comb_result", result, 32'd107);
    @(posedge clk);
    #1;
    check("hold_result_q", result_q, 32'd12);

    // clear beats hold
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("clear_result_q", result_q, 32'd0);
    check("clear_zero_q", {31'd0, zero_q}, 32'd0);

    @(negedge clk);
    clear = 1'b0;
    hold  = 1'b0;
    a     = 32'd5;
    @(posedge clk);
    #1;
    check("reload_result_q", result_q, 32'd12);

    // asynchronous reset between edges
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_result_q", result_q, 32'd0);
    check("async_rst_zero_q", {31'd0, zero_q}, 32'd0);
    check("async_rst_comb_result", result, 32'd12);
    #2;
    rst_n = 1'b1;
    check("rst_release_result_q", result_q, 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_result_q", result_q, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
